// File: rtl/spike_codec_pkg.sv
// Shared definitions for the spike rate decoder.
//   state_e       : decoder FSM states (idle / counting a window)
//   cnt_width()   : bit width needed to count 0..n-1 (never below 1)
//   rate_result_t : one window result {count, sat, isi_min}. Fields are sized to fixed
//                   maxima so the type can live in a package; users zero-extend into it
//                   and take the low bits back out.
package spike_codec_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StCount = 1'b1
  } state_e;

  localparam int unsigned MaxCountWidth = 32;
  localparam int unsigned MaxIsiWidth   = 32;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MaxCountWidth-1:0] count;
    logic                     sat;
    logic [MaxIsiWidth-1:0]   isi_min;
  } rate_result_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result handshake between the spike rate decoder and its consumer.
//   rate_valid : result register holds an unconsumed result (decoder -> consumer)
//   rate_ready : consumer accepts when rate_valid && rate_ready (consumer -> decoder)
//   rate_count : spike count of the window
//   rate_sat   : count saturated in that window
//   isi_min    : minimum inter-spike interval; only with SPIKE_RATE_DECODER_ISI_EN
interface spike_rate_decoder_if #(
  parameter int unsigned COUNT_WIDTH = 8
`ifdef SPIKE_RATE_DECODER_ISI_EN
  , parameter int unsigned ISI_WIDTH = 9
`endif
);

  logic                   rate_valid;
  logic                   rate_ready;
  logic [COUNT_WIDTH-1:0] rate_count;
  logic                   rate_sat;
`ifdef SPIKE_RATE_DECODER_ISI_EN
  logic [ISI_WIDTH-1:0]   isi_min;
`endif

  modport master (
`ifdef SPIKE_RATE_DECODER_ISI_EN
    output isi_min,
`endif
    output rate_valid,
    output rate_count,
    output rate_sat,
    input  rate_ready
  );

  modport slave (
`ifdef SPIKE_RATE_DECODER_ISI_EN
    input  isi_min,
`endif
    input  rate_valid,
    input  rate_count,
    input  rate_sat,
    output rate_ready
  );

endinterface

// File: rtl/spike_isi_tracker.sv
// Minimum inter-spike interval tracker for one counting window.
//   clk, rst_n  : clock, asynchronous active-low reset
//   active_i    : a window cycle is being counted this clock
//   win_start_i : this clock is the first cycle of a window
//   spike_i     : spike in this clock
//   isi_min_o   : running minimum including this clock's spike; all-ones until two
//                 spikes have been seen in the window. Valid to capture at window end.
module spike_isi_tracker #(
  parameter int unsigned ISI_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 active_i,
  input  logic                 win_start_i,
  input  logic                 spike_i,
  output logic [ISI_WIDTH-1:0] isi_min_o
);

  localparam logic [ISI_WIDTH-1:0] IsiOnes = '1;

  // dist_q: clocks elapsed since the last spike, as of the previous clock
  logic [ISI_WIDTH-1:0] dist_q, dist_d;
  logic [ISI_WIDTH-1:0] acc_q, acc_d;
  logic                 seen_q, seen_d;

  logic                 seen_eff;
  logic [ISI_WIDTH-1:0] acc_eff;
  logic [ISI_WIDTH-1:0] interval;
  logic [ISI_WIDTH-1:0] acc_new;

  always_comb begin
    // A new window forgets everything; a spike in its first cycle only starts timing.
    seen_eff = win_start_i ? 1'b0 : seen_q;
    acc_eff  = win_start_i ? IsiOnes : acc_q;
    interval = (dist_q == IsiOnes) ? IsiOnes : dist_q + 1'b1;
    acc_new  = acc_eff;
    if (spike_i && seen_eff && (interval < acc_eff)) begin
      acc_new = interval;
    end
    isi_min_o = acc_new;

    dist_d = dist_q;
    acc_d  = acc_q;
    seen_d = seen_q;
    if (active_i) begin
      acc_d  = acc_new;
      seen_d = seen_eff | spike_i;
      dist_d = spike_i ? '0 : interval;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q <= '0;
      acc_q  <= IsiOnes;
      seen_q <= 1'b0;
    end else begin
      dist_q <= dist_d;
      acc_q  <= acc_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes over back-to-back windows of WINDOW_CYCLES clocks
// and presents each window's count in a one-entry valid/ready result register.
// Optional feature macro: SPIKE_RATE_DECODER_ISI_EN adds the isi_min result field.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : high runs windows; low stops and discards the partial window
//   spike_in   : one spike per high cycle
//   busy       : FSM is counting
//   overrun    : sticky, a result was dropped because the register was full;
//                cleared by reset or a rising edge of enable
//   rate_if    : result handshake (rate_valid/ready/count/sat[/isi_min])
module spike_rate_decoder
  import spike_codec_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 256,
  parameter int unsigned COUNT_WIDTH   = 8,
  parameter int unsigned ISI_WIDTH     = $clog2(WINDOW_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic spike_in,
  output logic busy,
  output logic overrun,
  spike_rate_decoder_if.master rate_if
);

  localparam int unsigned            WinWidth = cnt_width(WINDOW_CYCLES);
  localparam logic [WinWidth-1:0]    WinLast  = WinWidth'(WINDOW_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CntMax   = '1;
  localparam logic [ISI_WIDTH-1:0]   IsiOnes  = '1;
  localparam rate_result_t ResetResult = '{
    count:   '0,
    sat:     1'b0,
    isi_min: MaxIsiWidth'(IsiOnes)
  };

  state_e                 state_q, state_d;
  logic [WinWidth-1:0]    win_cnt_q, win_cnt_d;
  logic [COUNT_WIDTH-1:0] spk_cnt_q, spk_cnt_d;
  logic                   sat_q, sat_d;
  logic                   enable_q;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  rate_result_t           result_q, result_d;

  logic                   offer;
  logic                   load;
  logic [COUNT_WIDTH-1:0] spk_final;
  logic                   sat_final;
  logic [ISI_WIDTH-1:0]   isi_final;
  rate_result_t           offer_res;

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    spk_cnt_d = spk_cnt_q;
    sat_d     = sat_q;
    offer     = 1'b0;
    spk_final = spk_cnt_q;
    sat_final = sat_q;

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d   = StCount;
          win_cnt_d = '0;
          spk_cnt_d = '0;
          sat_d     = 1'b0;
        end
      end
      StCount: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          // Count including this cycle's spike; the last window cycle uses it directly.
          if (spike_in) begin
            if (spk_cnt_q == CntMax) begin
              sat_final = 1'b1;
            end else begin
              spk_final = spk_cnt_q + 1'b1;
            end
          end
          if (win_cnt_q == WinLast) begin
            offer     = 1'b1;
            win_cnt_d = '0;
            spk_cnt_d = '0;
            sat_d     = 1'b0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            spk_cnt_d = spk_final;
            sat_d     = sat_final;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SPIKE_RATE_DECODER_ISI_EN
  logic counting;
  logic win_start;

  assign counting  = (state_q == StCount) && enable;
  assign win_start = counting && (win_cnt_q == '0);

  spike_isi_tracker #(
    .ISI_WIDTH (ISI_WIDTH)
  ) u_isi (
    .clk         (clk),
    .rst_n       (rst_n),
    .active_i    (counting),
    .win_start_i (win_start),
    .spike_i     (spike_in),
    .isi_min_o   (isi_final)
  );
`else
  assign isi_final = IsiOnes;
`endif

  always_comb begin
    offer_res = '{
      count:   MaxCountWidth'(spk_final),
      sat:     sat_final,
      isi_min: MaxIsiWidth'(isi_final)
    };
    // Single entry: a new result fits only if the slot is empty or draining this cycle.
    load     = offer && (!valid_q || rate_if.rate_ready);
    result_d = load ? offer_res : result_q;

    valid_d = valid_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (valid_q && rate_if.rate_ready) begin
      valid_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (enable && !enable_q) begin
      overrun_d = 1'b0;
    end else if (offer && !load) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
      spk_cnt_q <= '0;
      sat_q     <= 1'b0;
      enable_q  <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      result_q  <= ResetResult;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      spk_cnt_q <= spk_cnt_d;
      sat_q     <= sat_d;
      enable_q  <= enable;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      result_q  <= result_d;
    end
  end

  assign busy               = (state_q == StCount);
  assign overrun            = overrun_q;
  assign rate_if.rate_valid = valid_q;
  assign rate_if.rate_count = result_q.count[COUNT_WIDTH-1:0];
  assign rate_if.rate_sat   = result_q.sat;

  logic unused_result;
`ifdef SPIKE_RATE_DECODER_ISI_EN
  assign rate_if.isi_min = result_q.isi_min[ISI_WIDTH-1:0];
  assign unused_result   = ^{result_q.count[MaxCountWidth-1:COUNT_WIDTH],
                             result_q.isi_min[MaxIsiWidth-1:ISI_WIDTH]};
`else
  assign unused_result   = ^{result_q.count[MaxCountWidth-1:COUNT_WIDTH], result_q.isi_min};
`endif

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Converts the single-cycle spike train produced by a LIF neuron back into a numeric rate: counts spikes over fixed, back-to-back windows of WINDOW_CYCLES clocks and presents each window's count on a valid/ready output register. Sits downstream of a neuron's spike output, in the readout/classification path of the SNN, and is the decoding end of the neuron's current-to-spike encoding.

## Interface

- WINDOW_CYCLES, 256: window length in clocks; ≥2.
- COUNT_WIDTH, 8: width of the spike count; the count saturates at 2^COUNT_WIDTH-1.
- ISI_WIDTH, $clog2(WINDOW_CYCLES)+1: width of isi_min; used only when the ISI feature is compiled in.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high runs windows, low stops and discards the partial window.
- spike_in  in  1  spike pulse; every cycle it is high counts as one spike.
- busy  out  1  high while the FSM is in COUNT.
- rate_valid  out  1  result register holds an unconsumed result.
- rate_ready  in  1  consumer accepts when rate_valid && rate_ready.
- rate_count  out  COUNT_WIDTH  spike count of the window.
- rate_sat  out  1  count saturated in that window.
- overrun  out  1  sticky; a window result was dropped because the register was full.
- isi_min  out  ISI_WIDTH  minimum inter-spike interval in the window; present only with SPIKE_RATE_DECODER_ISI_EN.

## Operation

- FSM has two states:
  - IDLE → COUNT when enable is sampled high; both counters clear.
  - COUNT → IDLE when enable is sampled low; the partial window is discarded and no result is produced.
- In COUNT:
  - win_cnt increments each cycle.
  - spk_cnt increments on spike_in and saturates at max. Once spk_cnt has saturated, a sat flag is set.
- Window end is the cycle with win_cnt == WINDOW_CYCLES-1:
  - The spike in that cycle is included in the result.
  - The final count (including saturation) is offered to the result register.
  - win_cnt and spk_cnt clear, and the next window starts on the following cycle with no gap.
- Result register:
  - Loads the offered result if rate_valid is low, or if rate_valid && rate_ready in the same cycle.
  - Otherwise the new result is dropped, overrun is set, and rate_count, rate_sat and isi_min stay stable.
- rate_valid:
  - Falls on acceptance unless a new result loads in the same cycle.
  - Is independent of enable: a pending result survives enable going low.
- overrun clears only on reset or on the rising edge of enable.

## Timing

- Reset values: busy=0, rate_valid=0, rate_count=0, rate_sat=0, overrun=0, isi_min=all-ones. Internal counters clear and the FSM enters IDLE.
- Reset is asynchronous: outputs take their reset values immediately, including mid-window and with a result pending.
- Window timing:
  - enable is sampled high in cycle E, so busy=1 from E+1.
  - The first window covers cycles E+1 … E+WINDOW_CYCLES.
  - rate_valid rises at E+WINDOW_CYCLES+1, then every WINDOW_CYCLES cycles if results are consumed.
- Stopping: enable sampled low in cycle D gives busy=0 at D+1. spike_in in cycle D is ignored.
- Latency from the last window cycle to rate_valid: 1 clock.
- Result register is one entry, no skid buffer; rate_ready has no combinational path to any output.

## Configuration

- SPIKE_RATE_DECODER_ISI_EN defined:
  - Adds the isi_min port and an ISI tracker.
  - The interval counter restarts at each spike; on each spike after the first in the window, isi_min_acc = min(isi_min_acc, interval).
  - The accumulator resets to all-ones at window start and is captured with the count.
  - Fewer than two spikes in the window → isi_min = all-ones.
  - A spike in the first cycle of a window only starts the measurement; intervals do not cross window boundaries.
- Not defined: no isi_min port and no tracker logic; everything else is identical.

## Structure

- Shared package spike_codec_pkg holds:
  - the FSM state enum: IDLE, COUNT;
  - localparam helpers for counter widths;
  - the result struct {count, sat, isi_min}.
- Sub-module spike_isi_tracker is instantiated only under SPIKE_RATE_DECODER_ISI_EN. Counters and the result register stay inline.

## Test plan

All scenarios use WINDOW_CYCLES=16, COUNT_WIDTH=4, rate_ready=1 unless noted.

- enable high at E, one spike every 4 cycles starting E+1 → rate_valid at E+17, rate_count=4, rate_sat=0, isi_min=4.
- spike_in held high for a full window → rate_count=15, rate_sat=1.
- rate_ready low across two full windows → first result held stable, overrun=1, second result dropped; then ready=1 → first result accepted, rate_valid=0.
- enable low during the 8th window cycle → busy=0 next cycle, no result; re-enable → fresh window, count starts at 0, overrun cleared.
- Spike in the last window cycle coinciding with acceptance of the previous result → new result loads, count includes that spike, rate_valid stays 1, overrun=0.
- rst_n low mid-window with rate_valid=1 → all outputs at reset values immediately; after release the FSM is IDLE until enable is sampled high.
